// File: rtl/output_router.sv
// Write-back router: buffers per-row PE results in small FIFOs, packs SPAD_N
// elements into one spad word and writes it to that row's address region.
module output_router #(
  parameter int DATA_WIDTH      = 8,
  parameter int SPAD_DATA_WIDTH = 64,
  parameter int SPAD_N          = SPAD_DATA_WIDTH / DATA_WIDTH,
  parameter int ADDR_WIDTH      = 8,
  parameter int ROWS            = 4,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic                       i_reg_clear,
  input  logic                       i_flush,
  input  logic [ROWS*DATA_WIDTH-1:0] i_data,
  input  logic [ROWS-1:0]            i_data_valid,
  output logic                       o_ready,
  input  logic [ADDR_WIDTH-1:0]      i_start_addr,
  input  logic [ADDR_WIDTH-1:0]      i_row_stride,
  output logic                       o_spad_write_en,
  output logic [ADDR_WIDTH-1:0]      o_write_addr,
  output logic [SPAD_DATA_WIDTH-1:0] o_data_out,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW = (SPAD_N > 1) ? $clog2(SPAD_N) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_LOAD, S_WRITE, S_DONE} state_t;

  state_t                     state_reg, state_next;
  logic [RW-1:0]              sel_row_reg, last_reg;
  logic [KW-1:0]              k_reg;
  logic [SPAD_DATA_WIDTH-1:0] pack_reg;
  logic                       flush_reg;
  logic [ADDR_WIDTH-1:0]      wr_cnt_reg [ROWS];
  logic [ADDR_WIDTH-1:0]      addr_hold_reg;
  logic [SPAD_DATA_WIDTH-1:0] data_hold_reg;

  logic [CW-1:0]         fifo_count [ROWS];
  logic [DATA_WIDTH-1:0] fifo_head  [ROWS];
  logic [ROWS-1:0]       push_vec, pop_vec, full_vec;
  logic                  ready;
  logic                  found;
  logic [RW-1:0]         cand_row;
  logic [RW:0]           scan_idx;
  logic [ADDR_WIDTH-1:0] addr_calc;
  logic                  active;

  assign active = (state_reg == S_SCAN) || (state_reg == S_LOAD) || (state_reg == S_WRITE);
  assign ready  = active && !flush_reg && !(|full_vec);

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_fifo
      logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
      logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
      logic [CW-1:0]         count_reg;

      assign push_vec[gi]   = i_data_valid[gi] & ready;
      assign fifo_count[gi] = count_reg;
      assign fifo_head[gi]  = mem[rd_ptr_reg];
      assign full_vec[gi]   = (count_reg == CW'(FIFO_DEPTH));

      // Storage carries no reset; validity is tracked entirely by the pointers.
      always_ff @(posedge i_clk) begin
        if (push_vec[gi])
          mem[wr_ptr_reg] <= i_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else if (i_reg_clear) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push_vec[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop_vec[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({push_vec[gi], pop_vec[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  // Round-robin search beginning just after the last row served.
  always_comb begin
    found    = 1'b0;
    cand_row = '0;
    scan_idx = '0;
    for (int i = 1; i <= ROWS; i++) begin
      scan_idx = {1'b0, last_reg} + (RW+1)'(i);
      if (scan_idx >= (RW+1)'(ROWS))
        scan_idx = scan_idx - (RW+1)'(ROWS);
      if (!found && ((fifo_count[scan_idx[RW-1:0]] >= CW'(SPAD_N)) ||
                     (flush_reg && (fifo_count[scan_idx[RW-1:0]] != '0)))) begin
        found    = 1'b1;
        cand_row = scan_idx[RW-1:0];
      end
    end
  end

  assign addr_calc = i_start_addr + ADDR_WIDTH'(sel_row_reg) * i_row_stride
                   + wr_cnt_reg[sel_row_reg];

  always_comb begin
    state_next = state_reg;
    pop_vec    = '0;
    case (state_reg)
      S_IDLE:  if (i_en) state_next = S_SCAN;
      S_SCAN: begin
        if (found)          state_next = S_LOAD;
        else if (flush_reg) state_next = S_DONE;
      end
      S_LOAD: begin
        if (fifo_count[sel_row_reg] != '0)
          pop_vec[sel_row_reg] = 1'b1;
        // A flush drain may end early on the last buffered element.
        if ((k_reg == KW'(SPAD_N - 1)) || (fifo_count[sel_row_reg] == '0) ||
            (flush_reg && (fifo_count[sel_row_reg] == CW'(1))))
          state_next = S_WRITE;
      end
      S_WRITE: state_next = S_SCAN;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= S_IDLE;
      sel_row_reg   <= '0;
      last_reg      <= '0;
      k_reg         <= '0;
      pack_reg      <= '0;
      flush_reg     <= 1'b0;
      addr_hold_reg <= '0;
      data_hold_reg <= '0;
      for (int r = 0; r < ROWS; r++) wr_cnt_reg[r] <= '0;
    end else if (i_reg_clear) begin
      state_reg     <= S_IDLE;
      sel_row_reg   <= '0;
      last_reg      <= '0;
      k_reg         <= '0;
      pack_reg      <= '0;
      flush_reg     <= 1'b0;
      addr_hold_reg <= '0;
      data_hold_reg <= '0;
      for (int r = 0; r < ROWS; r++) wr_cnt_reg[r] <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: if (i_en) last_reg <= RW'(ROWS - 1);
        S_SCAN: begin
          if (found) begin
            sel_row_reg <= cand_row;
            last_reg    <= cand_row;
            pack_reg    <= '0;
            k_reg       <= '0;
          end
        end
        S_LOAD: begin
          if (pop_vec[sel_row_reg]) begin
            pack_reg[k_reg*DATA_WIDTH +: DATA_WIDTH] <= fifo_head[sel_row_reg];
            k_reg <= k_reg + 1'b1;
          end
        end
        S_WRITE: begin
          wr_cnt_reg[sel_row_reg] <= wr_cnt_reg[sel_row_reg] + 1'b1;
          addr_hold_reg           <= addr_calc;
          data_hold_reg           <= pack_reg;
        end
        S_DONE: begin
          flush_reg <= 1'b0;
          for (int r = 0; r < ROWS; r++) wr_cnt_reg[r] <= '0;
        end
        default: ;
      endcase
      if (i_flush && active)
        flush_reg <= 1'b1;
    end
  end

  assign o_ready         = ready;
  assign o_spad_write_en = (state_reg == S_WRITE);
  assign o_write_addr    = (state_reg == S_WRITE) ? addr_calc : addr_hold_reg;
  assign o_data_out      = (state_reg == S_WRITE) ? pack_reg  : data_hold_reg;
  assign o_busy          = (state_reg != S_IDLE);
  assign o_done          = (state_reg == S_DONE);

endmodule

// File: tb/tb_output_router.sv
// Directed bench for output_router: packing, round-robin order, flush padding,
// backpressure, address wrap and asynchronous reset mid-transfer.
module tb_output_router;
  localparam int DW = 8;
  localparam int SW = 64;
  localparam int AW = 8;
  localparam int R  = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_en;
  logic          i_reg_clear;
  logic          i_flush;
  logic [R*DW-1:0] i_data;
  logic [R-1:0]  i_data_valid;
  logic          o_ready;
  logic [AW-1:0] i_start_addr;
  logic [AW-1:0] i_row_stride;
  logic          o_spad_write_en;
  logic [AW-1:0] o_write_addr;
  logic [SW-1:0] o_data_out;
  logic          o_busy;
  logic          o_done;

  always #5 i_clk = ~i_clk;

  output_router #(
    .DATA_WIDTH(DW), .SPAD_DATA_WIDTH(SW), .ADDR_WIDTH(AW), .ROWS(R), .FIFO_DEPTH(16)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_reg_clear(i_reg_clear),
    .i_flush(i_flush), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_ready(o_ready), .i_start_addr(i_start_addr), .i_row_stride(i_row_stride),
    .o_spad_write_en(o_spad_write_en), .o_write_addr(o_write_addr),
    .o_data_out(o_data_out), .o_busy(o_busy), .o_done(o_done)
  );

  logic [AW-1:0] wa_q [$];
  logic [SW-1:0] wd_q [$];
  int done_cnt = 0;
  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge i_clk) begin
    if (o_spad_write_en) begin
      wa_q.push_back(o_write_addr);
      wd_q.push_back(o_data_out);
      $display("write addr=%02h data=%016h", o_write_addr, o_data_out);
    end
    if (o_done) done_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [63:0] word_of(input logic [7:0] base);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = base + 8'(k);
    return w;
  endfunction

  task automatic expect_write(input string tag, input logic [AW-1:0] addr, input logic [SW-1:0] data);
    logic [AW-1:0] a;
    logic [SW-1:0] d;
    a = 'x;
    d = 'x;
    if (wa_q.size() > 0) begin
      a = wa_q.pop_front();
      d = wd_q.pop_front();
    end
    check({tag, "_addr"}, 64'(a), 64'(addr));
    check({tag, "_data"}, d, data);
  endtask

  task automatic start_run();
    i_en = 1'b1;
    tick();
    i_en = 1'b0;
  endtask

  task automatic flush_and_wait(input string tag);
    int d0;
    d0 = done_cnt;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check({tag, "_ready_after_flush"}, 64'(o_ready), 64'd0);
    for (int t = 0; t < 200 && o_busy; t++) tick();
    tick();
    tick();
    check({tag, "_idle"}, 64'(o_busy), 64'd0);
    check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_reg_clear = 1'b0; i_flush = 1'b0;
    i_data = '0; i_data_valid = '0;
    i_start_addr = 8'h10; i_row_stride = 8'h20;
    tick();
    tick();
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_we", 64'(o_spad_write_en), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_addr", 64'(o_write_addr), 64'd0);
    check("rst_data", o_data_out, 64'd0);
    i_rst = 1'b0;
    tick();

    // Flush in IDLE has no effect
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    tick();
    check("idle_flush_busy", 64'(o_busy), 64'd0);
    check("idle_ready", 64'(o_ready), 64'd0);

    // Basic pack on row 0
    start_run();
    check("basic_busy", 64'(o_busy), 64'd1);
    check("basic_ready", 64'(o_ready), 64'd1);
    for (int n = 0; n < 8; n++) begin
      i_data_valid = 4'b0001;
      i_data[0 +: 8] = 8'(n + 1);
      tick();
    end
    i_data_valid = '0;
    repeat (20) tick();
    expect_write("basic", 8'h10, 64'h0807060504030201);
    check("basic_no_more", 64'(wa_q.size()), 64'd0);
    flush_and_wait("basic");

    // Round-robin across all rows, two batches
    start_run();
    for (int n = 0; n < 8; n++) begin
      i_data_valid = 4'b1111;
      for (int r = 0; r < R; r++) i_data[r*DW +: DW] = 8'(16*r + n);
      tick();
    end
    i_data_valid = '0;
    repeat (50) tick();
    expect_write("rr0", 8'h10, word_of(8'h00));
    expect_write("rr1", 8'h30, word_of(8'h10));
    expect_write("rr2", 8'h50, word_of(8'h20));
    expect_write("rr3", 8'h70, word_of(8'h30));
    for (int n = 0; n < 8; n++) begin
      i_data_valid = 4'b1111;
      for (int r = 0; r < R; r++) i_data[r*DW +: DW] = 8'(16*r + 8 + n);
      tick();
    end
    i_data_valid = '0;
    repeat (50) tick();
    expect_write("rr4", 8'h11, word_of(8'h08));
    expect_write("rr5", 8'h31, word_of(8'h18));
    expect_write("rr6", 8'h51, word_of(8'h28));
    expect_write("rr7", 8'h71, word_of(8'h38));
    check("rr_no_more", 64'(wa_q.size()), 64'd0);
    flush_and_wait("rr");

    // Flush of a partial word on row 2
    start_run();
    i_data_valid = 4'b0100;
    i_data[16 +: 8] = 8'hAA; tick();
    i_data[16 +: 8] = 8'hBB; tick();
    i_data[16 +: 8] = 8'hCC; tick();
    i_data_valid = '0;
    check("partial_ready_before", 64'(o_ready), 64'd1);
    flush_and_wait("partial");
    expect_write("partial", 8'h50, 64'h0000000000CCBBAA);
    check("partial_no_more", 64'(wa_q.size()), 64'd0);

    // Backpressure: row 1 fills while row 0 is served
    start_run();
    for (int n = 0; n < 18; n++) begin
      i_data_valid = (n < 8) ? 4'b0011 : 4'b0010;
      i_data[0 +: 8] = 8'(n);
      i_data[8 +: 8] = 8'(8'h40 + n);
      tick();
      if (n == 15) check("bp_ready_full", 64'(o_ready), 64'd0);
      if (n == 17) check("bp_ready_still_full", 64'(o_ready), 64'd0);
    end
    i_data_valid = '0;
    repeat (40) tick();
    expect_write("bp_row0", 8'h10, word_of(8'h00));
    expect_write("bp_row1a", 8'h30, word_of(8'h40));
    expect_write("bp_row1b", 8'h31, word_of(8'h48));
    check("bp_no_more", 64'(wa_q.size()), 64'd0);
    flush_and_wait("bp");

    // Address wrap on row 3
    i_start_addr = 8'hF0; i_row_stride = 8'h08;
    start_run();
    for (int n = 0; n < 16; n++) begin
      i_data_valid = 4'b1000;
      i_data[24 +: 8] = 8'(8'h60 + n);
      tick();
    end
    i_data_valid = '0;
    repeat (40) tick();
    expect_write("wrap0", 8'h08, word_of(8'h60));
    expect_write("wrap1", 8'h09, word_of(8'h68));
    flush_and_wait("wrap");

    // Asynchronous reset during the fourth pop
    i_start_addr = 8'h10; i_row_stride = 8'h20;
    start_run();
    for (int n = 0; n < 8; n++) begin
      i_data_valid = 4'b0001;
      i_data[0 +: 8] = 8'(8'h80 + n);
      tick();
    end
    i_data_valid = '0;
    repeat (4) tick();
    check("ar_busy_before", 64'(o_busy), 64'd1);
    i_rst = 1'b1;
    #1;
    check("ar_ready", 64'(o_ready), 64'd0);
    check("ar_we", 64'(o_spad_write_en), 64'd0);
    check("ar_busy", 64'(o_busy), 64'd0);
    check("ar_done", 64'(o_done), 64'd0);
    check("ar_addr", 64'(o_write_addr), 64'd0);
    check("ar_data", o_data_out, 64'd0);
    tick();
    tick();
    i_rst = 1'b0;
    repeat (12) tick();
    check("ar_no_write", 64'(wa_q.size()), 64'd0);
    start_run();
    for (int n = 0; n < 8; n++) begin
      i_data_valid = 4'b0001;
      i_data[0 +: 8] = 8'(8'h90 + n);
      tick();
    end
    i_data_valid = '0;
    repeat (20) tick();
    expect_write("ar_after", 8'h10, word_of(8'h90));
    check("ar_no_more", 64'(wa_q.size()), 64'd0);
    flush_and_wait("ar");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
